// File: rtl/majority_stream.sv
`default_nettype none
// ============================================================================
// Module   : majority_stream
// Brief    : Bit-serial majority voter with valid/ready input and result ports.
// Revision : 1.0 - initial release
// ============================================================================
module majority_stream #(
    parameter int N = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clear,
    input  logic                         in_valid,
    input  logic                         in_bit,
    output logic                         in_ready,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic                         out_major,
    output logic                         out_tie,
    output logic [$clog2(N+1)-1:0]       out_ones
);

    localparam int CW = $clog2(N+1);

    localparam logic [0:0] c_st_collect = 1'b0;
    localparam logic [0:0] c_st_result  = 1'b1;

    localparam logic [CW-1:0] c_last_bit = CW'(N - 1);
    localparam logic [CW:0]   c_n_wide   = (CW+1)'(N);

    logic [0:0]    r_state;
    logic [CW-1:0] r_bit_cnt;
    logic [CW-1:0] r_ones_cnt;
    logic          r_out_valid;
    logic          r_out_major;
    logic          r_out_tie;
    logic [CW-1:0] r_out_ones;

    logic [CW-1:0] w_ones_next;
    logic [CW:0]   w_ones_x2;

    // Ones count including the bit on the input this cycle; doubled at
    // CW+1 bits so the comparison against N cannot overflow.
    assign w_ones_next = r_ones_cnt + CW'(in_bit);
    assign w_ones_x2   = {w_ones_next, 1'b0};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_st_collect;
            r_bit_cnt   <= '0;
            r_ones_cnt  <= '0;
            r_out_valid <= 1'b0;
            r_out_major <= 1'b0;
            r_out_tie   <= 1'b0;
            r_out_ones  <= '0;
        end else if (clear) begin
            r_state     <= c_st_collect;
            r_bit_cnt   <= '0;
            r_ones_cnt  <= '0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                c_st_collect: begin
                    if (in_valid) begin
                        if (r_bit_cnt == c_last_bit) begin
                            r_state     <= c_st_result;
                            r_bit_cnt   <= '0;
                            r_ones_cnt  <= '0;
                            r_out_valid <= 1'b1;
                            r_out_ones  <= w_ones_next;
                            r_out_major <= (w_ones_x2 > c_n_wide);
                            r_out_tie   <= (w_ones_x2 == c_n_wide);
                        end else begin
                            r_bit_cnt  <= r_bit_cnt + 1'b1;
                            r_ones_cnt <= w_ones_next;
                        end
                    end
                end
                default: begin
                    if (out_ready) begin
                        r_state     <= c_st_collect;
                        r_out_valid <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign in_ready  = (r_state == c_st_collect);
    assign out_valid = r_out_valid;
    assign out_major = r_out_major;
    assign out_tie   = r_out_tie;
    assign out_ones  = r_out_ones;

endmodule
`default_nettype wire

// File: tb/tb_majority_stream.sv
`default_nettype none
// ============================================================================
// Module   : tb_majority_stream
// Brief    : Directed self-checking bench for majority_stream (N=32, 1, 5).
// Revision : 1.0 - initial release
// ============================================================================
module tb_majority_stream;

    logic       clk;
    logic       rst;
    logic       clear;
    logic       in_valid;
    logic       in_bit;
    logic       out_ready;
    logic       w_in_ready;
    logic       w_out_valid;
    logic       w_out_major;
    logic       w_out_tie;
    logic [5:0] w_out_ones;

    logic       in_valid1;
    logic       in_bit1;
    logic       w_in_ready1;
    logic       w_out_valid1;
    logic       w_out_major1;
    logic       w_out_tie1;
    logic [0:0] w_out_ones1;

    logic       in_valid5;
    logic       in_bit5;
    logic       w_in_ready5;
    logic       w_out_valid5;
    logic       w_out_major5;
    logic       w_out_tie5;
    logic [2:0] w_out_ones5;

    int r_checks;
    int r_failures;

    majority_stream #(.N(32)) u_dut32 (
        .clk(clk), .rst(rst), .clear(clear),
        .in_valid(in_valid), .in_bit(in_bit), .in_ready(w_in_ready),
        .out_valid(w_out_valid), .out_ready(out_ready),
        .out_major(w_out_major), .out_tie(w_out_tie), .out_ones(w_out_ones)
    );

    majority_stream #(.N(1)) u_dut1 (
        .clk(clk), .rst(rst), .clear(1'b0),
        .in_valid(in_valid1), .in_bit(in_bit1), .in_ready(w_in_ready1),
        .out_valid(w_out_valid1), .out_ready(1'b1),
        .out_major(w_out_major1), .out_tie(w_out_tie1), .out_ones(w_out_ones1)
    );

    majority_stream #(.N(5)) u_dut5 (
        .clk(clk), .rst(rst), .clear(1'b0),
        .in_valid(in_valid5), .in_bit(in_bit5), .in_ready(w_in_ready5),
        .out_valid(w_out_valid5), .out_ready(1'b1),
        .out_major(w_out_major5), .out_tie(w_out_tie5), .out_ones(w_out_ones5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        r_checks = r_checks + 1;
        if (got !== exp) begin
            r_failures = r_failures + 1;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Drives bits v[0..nbits-1] into the N=32 instance; inputs change on the
    // falling edge so each rising edge samples a stable beat.
    task automatic send_seq(input logic [31:0] v, input int nbits, input bit gaps);
        for (int i = 0; i < nbits; i++) begin
            if (gaps) begin
                int idle;
                idle = $urandom_range(0, 2);
                for (int k = 0; k < idle; k++) begin
                    in_valid = 1'b0;
                    @(negedge clk);
                end
            end
            in_valid = 1'b1;
            in_bit   = v[i];
            @(negedge clk);
            if (i == nbits - 2)
                check("no_early_result", 32'(w_out_valid), 32'd0);
        end
        in_valid = 1'b0;
        in_bit   = 1'b0;
    endtask

    task automatic check_result(input string tag, input int ones, input bit major, input bit tie);
        check({tag, "_valid"}, 32'(w_out_valid), 32'd1);
        check({tag, "_ready"}, 32'(w_in_ready), 32'd0);
        check({tag, "_ones"},  32'(w_out_ones), 32'(ones));
        check({tag, "_major"}, 32'(w_out_major), 32'(major));
        check({tag, "_tie"},   32'(w_out_tie), 32'(tie));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        r_checks   = 0;
        r_failures = 0;
        rst = 1'b1; clear = 1'b0; in_valid = 1'b0; in_bit = 1'b0; out_ready = 1'b1;
        in_valid1 = 1'b0; in_bit1 = 1'b0; in_valid5 = 1'b0; in_bit5 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        check("rst_in_ready",  32'(w_in_ready), 32'd1);
        check("rst_out_valid", 32'(w_out_valid), 32'd0);
        check("rst_major",     32'(w_out_major), 32'd0);
        check("rst_tie",       32'(w_out_tie), 32'd0);
        check("rst_ones",      32'(w_out_ones), 32'd0);

        // 20 ones then 12 zeros, valid held high
        send_seq(32'h000F_FFFF, 32, 1'b0);
        check_result("r20", 20, 1'b1, 1'b0);
        @(negedge clk);
        check("r20_accepted", 32'(w_out_valid), 32'd0);
        check("r20_reopen", 32'(w_in_ready), 32'd1);

        send_seq(32'h5555_5555, 32, 1'b0);
        check_result("tie16", 16, 1'b0, 1'b1);
        @(negedge clk);
        send_seq(32'h0000_0000, 32, 1'b0);
        check_result("zeros", 0, 1'b0, 1'b0);
        @(negedge clk);
        send_seq(32'hFFFF_FFFF, 32, 1'b0);
        check_result("ones", 32, 1'b1, 1'b0);
        @(negedge clk);

        // 17 ones with gaps, then hold off the consumer for 5 cycles
        out_ready = 1'b0;
        send_seq(32'h0001_FFFF, 32, 1'b1);
        check_result("r17", 17, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_bit   = 1'b1;
            @(negedge clk);
            check("hold_valid", 32'(w_out_valid), 32'd1);
            check("hold_ones",  32'(w_out_ones), 32'd17);
            check("hold_major", 32'(w_out_major), 32'd1);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("hold_released", 32'(w_out_valid), 32'd0);
        send_seq(32'hFFFF_FFFF, 32, 1'b0);
        check_result("fresh32", 32, 1'b1, 1'b0);
        @(negedge clk);

        // clear after 10 bits, with a bit presented alongside the clear
        send_seq(32'hFFFF_FFFF, 10, 1'b0);
        clear = 1'b1; in_valid = 1'b1; in_bit = 1'b1;
        @(negedge clk);
        clear = 1'b0; in_valid = 1'b0;
        send_seq(32'h0000_0000, 32, 1'b0);
        check_result("clr_partial", 0, 1'b0, 1'b0);
        @(negedge clk);

        out_ready = 1'b0;
        send_seq(32'h0000_0007, 32, 1'b0);
        check_result("pre_clr", 3, 1'b0, 1'b0);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        check("clr_res_valid", 32'(w_out_valid), 32'd0);
        check("clr_res_ready", 32'(w_in_ready), 32'd1);
        check("clr_res_ones",  32'(w_out_ones), 32'd3);
        out_ready = 1'b1;

        // rst after 31 bits drops the partial count
        send_seq(32'hFFFF_FFFF, 31, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        send_seq(32'h0000_0001, 1, 1'b0);
        check("rst_partial", 32'(w_out_valid), 32'd0);
        send_seq(32'h7FFF_FFFF, 31, 1'b0);
        check_result("post_rst", 32, 1'b1, 1'b0);
        @(negedge clk);

        out_ready = 1'b0;
        send_seq(32'h0000_001F, 32, 1'b0);
        check_result("pre_rst", 5, 1'b0, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_res_valid", 32'(w_out_valid), 32'd0);
        check("rst_res_ones",  32'(w_out_ones), 32'd0);
        check("rst_res_ready", 32'(w_in_ready), 32'd1);
        out_ready = 1'b1;

        // N=1 instance
        in_valid1 = 1'b1; in_bit1 = 1'b1;
        @(negedge clk);
        in_valid1 = 1'b0;
        check("n1_a_valid", 32'(w_out_valid1), 32'd1);
        check("n1_a_major", 32'(w_out_major1), 32'd1);
        check("n1_a_tie",   32'(w_out_tie1), 32'd0);
        check("n1_a_ones",  32'(w_out_ones1), 32'd1);
        @(negedge clk);
        check("n1_a_ready", 32'(w_in_ready1), 32'd1);
        in_valid1 = 1'b1; in_bit1 = 1'b0;
        @(negedge clk);
        in_valid1 = 1'b0;
        check("n1_b_valid", 32'(w_out_valid1), 32'd1);
        check("n1_b_major", 32'(w_out_major1), 32'd0);
        check("n1_b_tie",   32'(w_out_tie1), 32'd0);
        check("n1_b_ones",  32'(w_out_ones1), 32'd0);

        // N=5 instance: 1,1,0,0,1
        for (int i = 0; i < 5; i++) begin
            in_valid5 = 1'b1;
            in_bit5   = (i == 0 || i == 1 || i == 4);
            @(negedge clk);
            if (i == 3)
                check("n5_no_early", 32'(w_out_valid5), 32'd0);
        end
        in_valid5 = 1'b0;
        check("n5_valid", 32'(w_out_valid5), 32'd1);
        check("n5_ones",  32'(w_out_ones5), 32'd3);
        check("n5_major", 32'(w_out_major5), 32'd1);
        check("n5_tie",   32'(w_out_tie5), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", r_checks, r_failures);
        $finish;
    end

endmodule
`default_nettype wire
